// File: rtl/agc_loop_ctrl.sv
// AGC loop sequencing controller: picks fast/slow alpha, strobes EMA gain updates, freezes on gaps.
// Optional overload re-acquire path enabled by defining AGC_CTRL_OVERLOAD_EN.
module agc_loop_ctrl #(
  parameter int unsigned W_MAG    = 16,
  parameter int unsigned W_ALPHA  = 16,
  parameter int unsigned W_CNT    = 16,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic [W_ALPHA-1:0] i_alpha_fast,
  input  logic [W_ALPHA-1:0] i_alpha_slow,
  input  logic [W_MAG-1:0]   i_reference,
  input  logic [W_MAG-1:0]   i_lock_tol,
  input  logic [W_CNT-1:0]   i_acq_len,
  input  logic [W_CNT-1:0]   i_hold_len,
  input  logic [W_MAG-1:0]   s_mag_data,
  input  logic               s_mag_valid,
  output logic [W_ALPHA-1:0] o_alpha,
  output logic               o_gain_we,
  output logic               o_freeze,
  output logic [1:0]         o_state,
  output logic               o_locked,
  output logic               o_acq_timeout
);

  localparam int unsigned W_LCK = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

  state_t             r_state;
  logic [W_CNT-1:0]   r_acq_cnt;
  logic [W_CNT-1:0]   r_gap_cnt;
  logic [W_LCK-1:0]   r_lock_cnt;
  logic [W_ALPHA-1:0] r_alpha;
  logic               r_gain_we;
  logic               r_freeze;
  logic               r_locked;
  logic               r_acq_timeout;

  logic [W_MAG:0]     w_err;
  logic [W_MAG:0]     w_abs_err;
  logic               w_in_win;
  logic [W_LCK-1:0]   w_lock_nxt;
  logic               w_lock_hit;
  logic [W_CNT-1:0]   w_acq_inc;
  logic               w_acq_to;
  logic [W_CNT-1:0]   w_gap_inc;
  logic               w_hold_hit;

  // One extra bit keeps |mag - ref| exact, including mag=0, ref=full-scale.
  assign w_err      = {1'b0, s_mag_data} - {1'b0, i_reference};
  assign w_abs_err  = w_err[W_MAG] ? (~w_err + (W_MAG+1)'(1)) : w_err;
  assign w_in_win   = (w_abs_err <= {1'b0, i_lock_tol});

  assign w_lock_nxt = w_in_win ? (r_lock_cnt + W_LCK'(1)) : '0;
  assign w_lock_hit = (w_lock_nxt == W_LCK'(LOCK_CNT));
  assign w_acq_inc  = (r_acq_cnt == '1) ? r_acq_cnt : (r_acq_cnt + W_CNT'(1));
  assign w_acq_to   = (i_acq_len != '0) && (w_acq_inc >= i_acq_len);
  assign w_gap_inc  = (r_gap_cnt == '1) ? r_gap_cnt : (r_gap_cnt + W_CNT'(1));
  assign w_hold_hit = (i_hold_len != '0) && (w_gap_inc >= i_hold_len);

`ifdef AGC_CTRL_OVERLOAD_EN
  logic w_overload;
  assign w_overload = ({1'b0, s_mag_data} >= {i_reference, 1'b0});
`endif

  // Outputs are registered as a function of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_acq_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_lock_cnt    <= '0;
      r_alpha       <= '0;
      r_gain_we     <= 1'b0;
      r_freeze      <= 1'b1;
      r_locked      <= 1'b0;
      r_acq_timeout <= 1'b0;
    end else begin
      r_gain_we <= 1'b0;
      if (!i_enable) begin
        r_state       <= ST_IDLE;
        r_acq_cnt     <= '0;
        r_gap_cnt     <= '0;
        r_lock_cnt    <= '0;
        r_alpha       <= '0;
        r_freeze      <= 1'b1;
        r_locked      <= 1'b0;
        r_acq_timeout <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_ACQ;
            r_alpha    <= i_alpha_fast;
            r_freeze   <= 1'b0;
            r_locked   <= 1'b0;
            r_acq_cnt  <= '0;
            r_lock_cnt <= '0;
            r_gap_cnt  <= '0;
          end
          ST_ACQ: begin
            r_alpha  <= i_alpha_fast;
            r_freeze <= 1'b0;
            r_locked <= 1'b0;
            if (s_mag_valid) begin
              r_gain_we <= 1'b1;
              if (w_lock_hit) begin
                r_state    <= ST_TRACK;
                r_alpha    <= i_alpha_slow;
                r_locked   <= 1'b1;
                r_lock_cnt <= '0;
                r_acq_cnt  <= '0;
                r_gap_cnt  <= '0;
              end else if (w_acq_to) begin
                r_acq_timeout <= 1'b1;
                r_acq_cnt     <= '0;
                r_lock_cnt    <= w_lock_nxt;
              end else begin
                r_acq_cnt  <= w_acq_inc;
                r_lock_cnt <= w_lock_nxt;
              end
            end
          end
          ST_TRACK: begin
            r_alpha  <= i_alpha_slow;
            r_freeze <= 1'b0;
            r_locked <= 1'b1;
            if (s_mag_valid) begin
              r_gain_we <= 1'b1;
              r_gap_cnt <= '0;
`ifdef AGC_CTRL_OVERLOAD_EN
              if (w_overload) begin
                r_state    <= ST_ACQ;
                r_alpha    <= i_alpha_fast;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
                r_acq_cnt  <= '0;
              end
`endif
            end else if (w_hold_hit) begin
              r_state   <= ST_HOLD;
              r_freeze  <= 1'b1;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= w_gap_inc;
            end
          end
          ST_HOLD: begin
            r_alpha  <= i_alpha_slow;
            r_freeze <= 1'b1;
            r_locked <= 1'b1;
            // The waking sample only re-arms tracking; it is not strobed.
            if (s_mag_valid) begin
              r_state   <= ST_TRACK;
              r_freeze  <= 1'b0;
              r_gap_cnt <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_alpha       = r_alpha;
  assign o_gain_we     = r_gain_we;
  assign o_freeze      = r_freeze;
  assign o_state       = r_state;
  assign o_locked      = r_locked;
  assign o_acq_timeout = r_acq_timeout;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Scoreboard bench for agc_loop_ctrl: a behavioural model queues expected outputs per driven cycle.
module tb_agc_loop_ctrl;

  localparam int LOCK = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b0;
  logic [15:0] i_alpha_fast = 16'h1111;
  logic [15:0] i_alpha_slow = 16'h0222;
  logic [15:0] i_reference = 16'd1000;
  logic [15:0] i_lock_tol = 16'd16;
  logic [15:0] i_acq_len = 16'd0;
  logic [15:0] i_hold_len = 16'd0;
  logic [15:0] s_mag_data = 16'd0;
  logic        s_mag_valid = 1'b0;
  logic [15:0] o_alpha;
  logic        o_gain_we;
  logic        o_freeze;
  logic [1:0]  o_state;
  logic        o_locked;
  logic        o_acq_timeout;

  agc_loop_ctrl #(.W_MAG(16), .W_ALPHA(16), .W_CNT(16), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_alpha_fast(i_alpha_fast), .i_alpha_slow(i_alpha_slow),
    .i_reference(i_reference), .i_lock_tol(i_lock_tol),
    .i_acq_len(i_acq_len), .i_hold_len(i_hold_len),
    .s_mag_data(s_mag_data), .s_mag_valid(s_mag_valid),
    .o_alpha(o_alpha), .o_gain_we(o_gain_we), .o_freeze(o_freeze),
    .o_state(o_state), .o_locked(o_locked), .o_acq_timeout(o_acq_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, alpha, we, frz, lk, to;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_bad = 0;

  // Behavioural model state.
  int m_st, m_alpha, m_we, m_frz, m_lk, m_to, m_lc, m_ac, m_gc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_alpha = 0; m_we = 0; m_frz = 1; m_lk = 0; m_to = 0;
    m_lc = 0; m_ac = 0; m_gc = 0;
  endtask

  task automatic model_step();
    int d, r, diff, nl, na, ng;
    bit win;
    d = int'(s_mag_data);
    r = int'(i_reference);
    diff = (d > r) ? d - r : r - d;
    win = (diff <= int'(i_lock_tol));
    m_we = 0;
    if (!i_enable) begin
      m_st = 0; m_alpha = 0; m_frz = 1; m_lk = 0; m_to = 0; m_lc = 0; m_ac = 0; m_gc = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_alpha = int'(i_alpha_fast); m_frz = 0; m_lk = 0; m_lc = 0; m_ac = 0; m_gc = 0;
    end else if (m_st == 1) begin
      m_alpha = int'(i_alpha_fast); m_frz = 0; m_lk = 0;
      if (s_mag_valid) begin
        m_we = 1;
        nl = win ? m_lc + 1 : 0;
        na = (m_ac < 65535) ? m_ac + 1 : m_ac;
        if (nl >= LOCK) begin
          m_st = 2; m_alpha = int'(i_alpha_slow); m_lk = 1; m_lc = 0; m_ac = 0; m_gc = 0;
        end else if (i_acq_len != 0 && na >= int'(i_acq_len)) begin
          m_to = 1; m_ac = 0; m_lc = nl;
        end else begin
          m_ac = na; m_lc = nl;
        end
      end
    end else if (m_st == 2) begin
      m_alpha = int'(i_alpha_slow); m_frz = 0; m_lk = 1;
      if (s_mag_valid) begin
        m_we = 1; m_gc = 0;
`ifdef AGC_CTRL_OVERLOAD_EN
        if (d >= 2 * r) begin
          m_st = 1; m_alpha = int'(i_alpha_fast); m_lk = 0; m_lc = 0; m_ac = 0;
        end
`endif
      end else begin
        ng = (m_gc < 65535) ? m_gc + 1 : m_gc;
        if (i_hold_len != 0 && ng >= int'(i_hold_len)) begin
          m_st = 3; m_frz = 1; m_gc = 0;
        end else begin
          m_gc = ng;
        end
      end
    end else begin
      m_alpha = int'(i_alpha_slow); m_frz = 1; m_lk = 1;
      if (s_mag_valid) begin
        m_st = 2; m_frz = 0; m_gc = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
  task automatic cyc(input logic en, input logic v, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    i_enable = en; s_mag_valid = v; s_mag_data = d;
    model_step();
    e.st = m_st; e.alpha = m_alpha; e.we = m_we; e.frz = m_frz; e.lk = m_lk; e.to = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("state",   32'(o_state),       32'(e.st));
    chk("alpha",   32'(o_alpha),       32'(e.alpha));
    chk("gain_we", 32'(o_gain_we),     32'(e.we));
    chk("freeze",  32'(o_freeze),      32'(e.frz));
    chk("locked",  32'(o_locked),      32'(e.lk));
    chk("timeout", 32'(o_acq_timeout), 32'(e.to));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  32'(o_state),       32'd0);
    chk({tag, "_alpha"},  32'(o_alpha),       32'd0);
    chk({tag, "_we"},     32'(o_gain_we),     32'd0);
    chk({tag, "_freeze"}, 32'(o_freeze),      32'd1);
    chk({tag, "_locked"}, 32'(o_locked),      32'd0);
    chk({tag, "_to"},     32'(o_acq_timeout), 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;

    // Reset / enable
    cyc(0, 0, 0);
    chk("idle_state", 32'(o_state), 32'd0);
    cyc(1, 0, 0);
    chk("en_state", 32'(o_state), 32'd1);
    chk("en_alpha", 32'(o_alpha), 32'h1111);

    // Lock with a restart and window edges
    repeat (4) cyc(1, 1, 16'd1010);
    cyc(1, 1, 16'd1020);
    cyc(1, 1, 16'd983);
    cyc(1, 0, 0);
    cyc(1, 1, 16'd1016);
    cyc(1, 1, 16'd984);
    repeat (5) cyc(1, 1, 16'd1010);
    chk("prelock_state", 32'(o_state), 32'd1);
    cyc(1, 1, 16'd1010);
    chk("lock_state", 32'(o_state), 32'd2);
    chk("lock_locked", 32'(o_locked), 32'd1);
    chk("lock_alpha", 32'(o_alpha), 32'h0222);

    // Hold entry and exit
    i_hold_len = 16'd5;
    repeat (4) cyc(1, 0, 0);
    chk("prehold_state", 32'(o_state), 32'd2);
    cyc(1, 0, 0);
    chk("hold_state", 32'(o_state), 32'd3);
    chk("hold_freeze", 32'(o_freeze), 32'd1);
    cyc(1, 1, 16'd1000);
    chk("wake_state", 32'(o_state), 32'd2);
    chk("wake_we", 32'(o_gain_we), 32'd0);
    cyc(1, 1, 16'd1000);
    chk("wake2_we", 32'(o_gain_we), 32'd1);

    // Disable coincident with a valid sample
    cyc(0, 1, 16'd1000);
    chk("dis_state", 32'(o_state), 32'd0);
    chk("dis_we", 32'(o_gain_we), 32'd0);

    // Overload stimulus in TRACK
    cyc(1, 0, 0);
    repeat (LOCK) cyc(1, 1, 16'd1000);
    cyc(1, 1, 16'd2000);
`ifdef AGC_CTRL_OVERLOAD_EN
    chk("ovl_state", 32'(o_state), 32'd1);
`else
    chk("ovl_state", 32'(o_state), 32'd2);
`endif
    chk("ovl_we", 32'(o_gain_we), 32'd1);
    cyc(0, 0, 0);

    // Acquire timeout
    i_acq_len = 16'd20;
    cyc(1, 0, 0);
    repeat (19) cyc(1, 1, 16'd500);
    chk("preto", 32'(o_acq_timeout), 32'd0);
    cyc(1, 1, 16'd500);
    chk("to_flag", 32'(o_acq_timeout), 32'd1);
    chk("to_state", 32'(o_state), 32'd1);
    chk("to_we", 32'(o_gain_we), 32'd1);
    cyc(1, 1, 16'd500);
    chk("to_sticky", 32'(o_acq_timeout), 32'd1);

    // Lock and timeout on the same sample: lock wins
    cyc(0, 0, 0);
    chk("to_clr", 32'(o_acq_timeout), 32'd0);
    i_acq_len = 16'd8;
    cyc(1, 0, 0);
    repeat (LOCK) cyc(1, 1, 16'd1000);
    chk("tie_state", 32'(o_state), 32'd2);
    chk("tie_to", 32'(o_acq_timeout), 32'd0);

    // Full-scale negative error
    cyc(0, 0, 0);
    i_acq_len = 16'd0; i_reference = 16'hFFFF; i_lock_tol = 16'hFFFE;
    cyc(1, 0, 0);
    repeat (LOCK) cyc(1, 1, 16'd0);
    chk("fs_out_state", 32'(o_state), 32'd1);
    i_lock_tol = 16'hFFFF;
    repeat (LOCK) cyc(1, 1, 16'd0);
    chk("fs_in_state", 32'(o_state), 32'd2);

    // Async reset mid-ACQUIRE
    cyc(0, 0, 0);
    i_reference = 16'd1000; i_lock_tol = 16'd16;
    cyc(1, 0, 0);
    repeat (3) cyc(1, 1, 16'd1010);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    model_reset();
    @(negedge clk);
    i_enable = 1'b0;
    reset = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic en, v;
      logic [15:0] d;
      if (i % 50 == 0) begin
        i_hold_len = 16'($urandom_range(0, 6));
        i_acq_len  = 16'($urandom_range(0, 30));
      end
      en = ($urandom_range(0, 30) != 0);
      v  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       d = 16'd2000;
        1:       d = 16'd500;
        default: d = 16'(980 + $urandom_range(0, 40));
      endcase
      cyc(en, v, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
